// File: rtl/axis_sample_accumulator.sv
// AXI-Stream sink that tracks the latest sample and sums N signed beats
// on request, exposing the result on a status bus for PS readout.
module axis_sample_accumulator #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 16,
    parameter int ACC_WIDTH        = 48
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [CNTR_WIDTH-1:0]       cfg_data,
    input  logic                        cfg_start,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] sts_last,
    output logic [ACC_WIDTH-1:0]        sts_sum,
    output logic [CNTR_WIDTH-1:0]       sts_count,
    output logic                        sts_busy,
    output logic                        sts_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int EXT_W = ACC_WIDTH - AXIS_TDATA_WIDTH;

    state_t                        state_q, state_d;
    logic                          tready_q;
    logic [AXIS_TDATA_WIDTH-1:0]   last_q, last_d;
    logic [ACC_WIDTH-1:0]          sum_q, sum_d;
    logic [ACC_WIDTH-1:0]          acc_q, acc_d;
    logic [CNTR_WIDTH-1:0]         count_q, count_d;
    logic [CNTR_WIDTH-1:0]         n_q, n_d;
    logic                          beat;
    logic [ACC_WIDTH-1:0]          sample_ext;

    assign beat       = s_axis_tvalid & tready_q;
    assign sample_ext = {{EXT_W{s_axis_tdata[AXIS_TDATA_WIDTH-1]}}, s_axis_tdata};

    // State and datapath registers; tready rises on the first edge out of reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            last_q   <= '0;
            sum_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            n_q      <= '0;
        end else begin
            state_q  <= state_d;
            tready_q <= 1'b1;
            last_q   <= last_d;
            sum_q    <= sum_d;
            acc_q    <= acc_d;
            count_q  <= count_d;
            n_q      <= n_d;
        end
    end

    // Next-state logic: start handling in IDLE/DONE, beat accumulation in ACCUM.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sum_d   = sum_q;
        acc_d   = acc_q;
        count_d = count_q;
        n_d     = n_q;

        if (beat) begin
            last_d = s_axis_tdata;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (cfg_start) begin
                    n_d     = cfg_data;
                    acc_d   = '0;
                    count_d = '0;
                    if (cfg_data != '0) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = DONE;
                        sum_d   = '0;
                    end
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = acc_q + sample_ext;
                    count_d = count_q + CNTR_WIDTH'(1);
                    if (count_d == n_q) begin
                        state_d = DONE;
                        sum_d   = acc_d;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign s_axis_tready = tready_q;
    assign sts_last      = last_q;
    assign sts_sum       = sum_q;
    assign sts_count     = count_q;
    assign sts_busy      = (state_q == ACCUM);
    assign sts_done      = (state_q == DONE);

endmodule

// File: tb/tb_axis_sample_accumulator.sv
// Scoreboard bench for axis_sample_accumulator: directed runs push the
// expected completion record; a monitor checks it when sts_done rises.
module tb_axis_sample_accumulator;

    logic        aclk;
    logic        aresetn;
    logic [15:0] cfg_data;
    logic        cfg_start;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] sts_last;
    logic [47:0] sts_sum;
    logic [15:0] sts_count;
    logic        sts_busy;
    logic        sts_done;

    typedef struct {
        logic [47:0] sum;
        logic [15:0] cnt;
        logic [31:0] last;
    } exp_t;

    exp_t exp_q[$];
    int   tests;
    int   fails;
    logic done_prev;

    axis_sample_accumulator #(
        .AXIS_TDATA_WIDTH(32),
        .CNTR_WIDTH(16),
        .ACC_WIDTH(48)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .cfg_data(cfg_data),
        .cfg_start(cfg_start),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .sts_last(sts_last),
        .sts_sum(sts_sum),
        .sts_count(sts_count),
        .sts_busy(sts_busy),
        .sts_done(sts_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic start(input logic [15:0] n);
        cfg_data  = n;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        s_axis_tdata  = d;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    task automatic push(input logic [47:0] s, input logic [15:0] c,
                        input logic [31:0] l);
        exp_t e;
        e.sum  = s;
        e.cnt  = c;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Monitor: a rising sts_done marks a completed run.
    always @(negedge aclk) begin
        if (sts_done && !done_prev) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_sum", 64'(sts_sum), 64'(e.sum));
                chk("sb_count", 64'(sts_count), 64'(e.cnt));
                chk("sb_last", 64'(sts_last), 64'(e.last));
                chk("sb_busy", 64'(sts_busy), 64'd0);
            end
        end
        done_prev <= sts_done;
    end

    initial begin
        int to;
        tests         = 0;
        fails         = 0;
        done_prev     = 1'b0;
        aresetn       = 1'b0;
        cfg_data      = '0;
        cfg_start     = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;

        // Reset state
        #22;
        chk("rst_tready", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        chk("rel_tready", 64'(s_axis_tready), 64'd1);
        chk("rel_sum", 64'(sts_sum), 64'd0);
        chk("rel_last", 64'(sts_last), 64'd0);
        chk("rel_count", 64'(sts_count), 64'd0);
        chk("rel_busy", 64'(sts_busy), 64'd0);
        chk("rel_done", 64'(sts_done), 64'd0);

        // N=4 with tvalid gaps: 10-3+7+5 = 19
        push(48'd19, 16'd4, 32'd5);
        start(16'd4);
        chk("t2_busy", 64'(sts_busy), 64'd1);
        beat(32'd10);
        tick();
        beat(-32'sd3);
        tick();
        beat(32'd7);
        tick();
        chk("t2_busy_mid", 64'(sts_busy), 64'd1);
        chk("t2_count_mid", 64'(sts_count), 64'd3);
        chk("t2_sum_hold", 64'(sts_sum), 64'd0);
        beat(32'd5);
        chk("t2_done", 64'(sts_done), 64'd1);

        // Restart from DONE, N=2 of max positive samples
        push(48'h0000_FFFF_FFFE, 16'd2, 32'h7FFF_FFFF);
        start(16'd2);
        beat(32'h7FFF_FFFF);
        beat(32'h7FFF_FFFF);
        for (int i = 1; i <= 3; i++) begin
            beat(32'(i));
        end
        chk("t3_sum_hold", 64'(sts_sum), 64'h0000_FFFF_FFFE);
        chk("t3_count_hold", 64'(sts_count), 64'd2);
        chk("t3_last", 64'(sts_last), 64'd3);
        chk("t3_done", 64'(sts_done), 64'd1);

        // Reset back to IDLE, then N=0
        aresetn = 1'b0;
        tick();
        chk("r2_sum", 64'(sts_sum), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        push(48'd0, 16'd0, 32'd0);
        start(16'd0);
        chk("t4_busy", 64'(sts_busy), 64'd0);
        chk("t4_done", 64'(sts_done), 64'd1);
        tick();

        // N=3, start mid-run ignored: 1+2+4 = 7
        push(48'd7, 16'd3, 32'd4);
        start(16'd3);
        beat(32'd1);
        beat(32'd2);
        start(16'd1);
        chk("t5_busy", 64'(sts_busy), 64'd1);
        chk("t5_count", 64'(sts_count), 64'd2);
        beat(32'd4);
        chk("t5_done", 64'(sts_done), 64'd1);

        // Async reset mid-run, then N=1 with negative sample
        start(16'd5);
        beat(32'd9);
        beat(32'd9);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_sum", 64'(sts_sum), 64'd0);
        chk("t6_count", 64'(sts_count), 64'd0);
        chk("t6_busy", 64'(sts_busy), 64'd0);
        chk("t6_last", 64'(sts_last), 64'd0);
        chk("t6_tready", 64'(s_axis_tready), 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        push(48'hFFFF_FFFF_FFF8, 16'd1, 32'hFFFF_FFF8);
        start(16'd1);
        beat(32'hFFFF_FFF8);

        // N = 2^16-1 continuous max samples: count must not wrap
        push(48'h7FFF_7FFF_0001, 16'hFFFF, 32'h7FFF_FFFF);
        start(16'hFFFF);
        s_axis_tdata  = 32'h7FFF_FFFF;
        s_axis_tvalid = 1'b1;
        to = 0;
        while (!sts_done && to < 70000) begin
            tick();
            to++;
        end
        s_axis_tvalid = 1'b0;
        chk("big_done", 64'(sts_done), 64'd1);
        chk("big_count", 64'(sts_count), 64'hFFFF);

        // Drain the scoreboard
        to = 0;
        while (exp_q.size() != 0 && to < 20) begin
            tick();
            to++;
        end
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
